// File: rtl/count_bank_pkg.sv
// Shared types and mode constants for the count_bank counter bank.
package count_bank_pkg;

    typedef struct packed {
        logic saturate;
        logic down;
    } mode_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } ch_state_t;

    localparam mode_t MODE_UP_WRAP   = '{saturate: 1'b0, down: 1'b0};
    localparam mode_t MODE_DOWN_WRAP = '{saturate: 1'b0, down: 1'b1};
    localparam mode_t MODE_UP_SAT    = '{saturate: 1'b1, down: 1'b0};
    localparam mode_t MODE_DOWN_SAT  = '{saturate: 1'b1, down: 1'b1};

endpackage

// File: rtl/count_chan.sv
// One counter channel: shadow/active config, IDLE/RUN/HOLD FSM, counter, tc and sticky done.
module count_chan
    import count_bank_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             cfg_wr,
    input  logic [WIDTH-1:0] cfg_limit,
    input  mode_t            cfg_mode,
    input  logic             start,
    input  logic             en,
    input  logic             clear_done,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             done,
    output logic             tc_next
);

    ch_state_t        state, state_n;
    logic [WIDTH-1:0] sh_limit, sh_limit_n, act_limit, act_limit_n;
    mode_t            sh_mode, sh_mode_n, act_mode, act_mode_n;
    logic [WIDTH-1:0] count_n, terminal, start_val, step;
    logic             done_n;

    assign terminal  = act_mode.down ? '0 : act_limit;
    assign start_val = act_mode.down ? act_limit : '0;
    assign step      = act_mode.down ? count - WIDTH'(1) : count + WIDTH'(1);

    // A config write in the same cycle as start is picked up by that start.
    always_comb begin
        state_n     = state;
        count_n     = count;
        tc_next     = 1'b0;
        done_n      = done;
        sh_limit_n  = cfg_wr ? cfg_limit : sh_limit;
        sh_mode_n   = cfg_wr ? cfg_mode  : sh_mode;
        act_limit_n = act_limit;
        act_mode_n  = act_mode;
        if (start) begin
            act_limit_n = sh_limit_n;
            act_mode_n  = sh_mode_n;
            count_n     = sh_mode_n.down ? sh_limit_n : '0;
            if (sh_limit_n == '0) begin
                state_n = HOLD;
                tc_next = 1'b1;
            end else begin
                state_n = RUN;
            end
        end else if (state == RUN && en) begin
            if (count == terminal) begin
                count_n = start_val;
            end else begin
                count_n = step;
                if (step == terminal) begin
                    tc_next = 1'b1;
                    if (act_mode.saturate) state_n = HOLD;
                end
            end
        end
        if (tc_next)         done_n = 1'b1;
        else if (clear_done) done_n = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state     <= IDLE;
            count     <= '0;
            tc        <= 1'b0;
            done      <= 1'b0;
            sh_limit  <= '0;
            sh_mode   <= MODE_UP_WRAP;
            act_limit <= '0;
            act_mode  <= MODE_UP_WRAP;
        end else begin
            state     <= state_n;
            count     <= count_n;
            tc        <= tc_next;
            done      <= done_n;
            sh_limit  <= sh_limit_n;
            sh_mode   <= sh_mode_n;
            act_limit <= act_limit_n;
            act_mode  <= act_mode_n;
        end
    end

    always @(posedge clk) begin
        if (reset_l) begin
            assert (count <= act_limit);
            if (tc) assert (count == terminal);
        end
    end

    cover property (@(posedge clk) disable iff (!reset_l) tc && act_mode == MODE_UP_WRAP);
    cover property (@(posedge clk) disable iff (!reset_l) tc && act_mode == MODE_DOWN_WRAP);
    cover property (@(posedge clk) disable iff (!reset_l) tc && act_mode == MODE_UP_SAT);
    cover property (@(posedge clk) disable iff (!reset_l) tc && act_mode == MODE_DOWN_SAT);
    cover property (@(posedge clk) disable iff (!reset_l) !start && state == RUN && en && count == terminal);
    cover property (@(posedge clk) disable iff (!reset_l) start && state == RUN);
    cover property (@(posedge clk) disable iff (!reset_l) clear_done && tc_next);

endmodule

// File: rtl/count_bank.sv
// Bank of NUM_CH counter channels with config decode, armed tracking and a finish request pulse.
module count_bank
    import count_bank_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int WIDTH  = 32,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    reset_l,
    input  logic                    cfg_wr_en,
    input  logic [CH_W-1:0]         cfg_ch,
    input  logic [WIDTH-1:0]        cfg_limit,
    input  logic [1:0]              cfg_mode,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH-1:0]       clear_done,
    output logic [NUM_CH*WIDTH-1:0] count_o,
    output logic [NUM_CH-1:0]       tc_o,
    output logic [NUM_CH-1:0]       done_o,
    output logic [NUM_CH-1:0]       armed_o,
    output logic                    finish_req_o
);

    logic [NUM_CH-1:0] tc_next;
    logic [NUM_CH-1:0] armed_n;
    logic              all_done, all_done_q, finish_prev;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        count_chan #(.WIDTH(WIDTH)) u_chan (
            .clk        (clk),
            .reset_l    (reset_l),
            .cfg_wr     (cfg_wr_en && (cfg_ch == CH_W'(i))),
            .cfg_limit  (cfg_limit),
            .cfg_mode   (mode_t'(cfg_mode)),
            .start      (start[i]),
            .en         (en[i]),
            .clear_done (clear_done[i]),
            .count      (count_o[i*WIDTH +: WIDTH]),
            .tc         (tc_o[i]),
            .done       (done_o[i]),
            .tc_next    (tc_next[i])
        );
    end

    // A terminal count landing on the same edge as clear_done keeps the channel armed.
    assign armed_n  = start | (armed_o & ~(clear_done & ~tc_next));
    assign all_done = (armed_o != '0) && ((armed_o & ~done_o) == '0);

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            armed_o      <= '0;
            all_done_q   <= 1'b0;
            finish_req_o <= 1'b0;
            finish_prev  <= 1'b0;
        end else begin
            armed_o      <= armed_n;
            all_done_q   <= all_done;
            finish_req_o <= all_done && !all_done_q;
            finish_prev  <= finish_req_o;
        end
    end

    always @(posedge clk) begin
        if (reset_l) assert (!(finish_req_o && finish_prev));
    end

endmodule

// File: doc/count_bank.md
Name: count_bank

Overview:
- Parametrised bank of NUM_CH independent counters, each WIDTH bits, each with a programmable limit and a per-channel mode (up/down, wrap/saturate).
- Successor to the single fixed free-running test counter. Used by test harnesses and simple sequencers to time events and to signal run completion.
- Raises a per-channel terminal-count pulse and a sticky done flag. Raises a bank-level finish request once every armed channel has completed.

Parameters:
- NUM_CH, 4, number of counter channels (1..16)
- WIDTH, 32, counter and limit width in bits (2..64)
- CH_W, $clog2(NUM_CH) with a minimum of 1, localparam, width of the channel select

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset_l  in  1  asynchronous active-low reset
- cfg_wr_en  in  1  write cfg_limit/cfg_mode into channel cfg_ch's shadow registers
- cfg_ch  in  CH_W  channel selected for the configuration write; values >= NUM_CH are ignored
- cfg_limit  in  WIDTH  terminal limit value
- cfg_mode  in  2  bit0: 1=down, 0=up; bit1: 1=saturate, 0=wrap
- start  in  NUM_CH  per-channel arm/restart strobe
- en  in  NUM_CH  per-channel count enable
- clear_done  in  NUM_CH  per-channel clear for done_o
- count_o  out  NUM_CH*WIDTH  current counts; channel i occupies bits [i*WIDTH +: WIDTH]
- tc_o  out  NUM_CH  one-cycle terminal-count pulse
- done_o  out  NUM_CH  sticky completion flag
- armed_o  out  NUM_CH  channel has been started since reset or its last clear_done
- finish_req_o  out  1  one-cycle pulse when every armed channel is done

Behaviour:
- Reset (asynchronous): every output is 0; all channels IDLE; shadow limit = 0, shadow mode = 0; active limit/mode = 0.
- Per-channel states:
  - IDLE: count holds; en is ignored.
  - RUN: counting.
  - HOLD: saturated; count frozen at the terminal value.
- Configuration goes only to the shadow registers. Shadow values are copied to the active registers on start. A write to a running channel never changes the current run.
- Start value and terminal value, taken from the active registers:
  - up mode: start value 0, terminal = limit.
  - down mode: start value = limit, terminal 0.
- start[i], from any state:
  - load the start value, enter RUN, set armed_o[i].
  - start has priority over en in the same cycle, so no increment happens that cycle.
  - done_o[i] is not cleared by start.
- RUN with en[i]=1, all arithmetic modulo 2^WIDTH:
  - next = count+1 (up) or count-1 (down).
  - If next equals the terminal: tc_o[i]=1 in the following cycle, i.e. in the same cycle count_o shows the terminal value. done_o[i] is set on that edge.
  - Wrap mode: on the next en cycle after reaching the terminal, count reloads the start value (no terminal-to-terminal+1 step) and the channel stays in RUN.
  - Saturate mode: enter HOLD at the terminal.
- RUN with en[i]=0: hold the count; no tc.
- Zero-length run (limit==0 at start, either mode): the loaded value already equals the terminal. tc_o[i] pulses in the cycle after start, done_o[i] is set, the channel enters HOLD, and en is ignored until the next start.
- clear_done[i]:
  - Clears done_o[i] and armed_o[i].
  - If a tc set occurs on the same edge, the set wins and armed_o[i] stays 1.
- finish_req_o:
  - Pulses for one cycle on the 0->1 transition of (armed_o != 0) && ((armed_o & ~done_o) == 0).
  - It does not re-pulse while that condition stays true.
- Invariants (implement as immediate assertions, disabled while reset_l=0):
  - in up mode, count <= active limit;
  - in down mode, count <= active limit;
  - tc_o[i] implies count_o channel i == terminal;
  - finish_req_o is never high for 2 consecutive cycles.
- Coverage points per channel: tc in each of the 4 modes; wrap reload; start while in RUN; clear_done colliding with tc.
- Reset asserted mid-run: immediate return to the reset state; no tc or finish pulse is generated.

Decomposition:
- Package count_bank_pkg:
  - mode_t (struct with down and saturate bits);
  - ch_state_t enum {IDLE, RUN, HOLD};
  - MODE_UP_WRAP etc. constants.
- One sub-module, count_chan:
  - holds one channel's shadow/active regs, FSM, counter, tc and done;
  - instantiated NUM_CH times via generate.
- The top level holds the config decode, armed/finish logic, and the count_o packing.

Test Plan:
- Reset mid-run: NUM_CH=4, WIDTH=8; ch0 up/wrap limit 3; start, hold en=1 -> count_o ch0 runs 0,1,2,3,0,1...; tc_o[0] high in each cycle the count shows 3; done_o[0] set after the first tc; reset_l low mid-run -> all outputs 0 immediately.
- Saturate and collision: ch1 down/saturate limit 5; start then en=1 -> count 5,4,3,2,1,0 then held at 0; a single tc_o[1]; en toggling afterwards has no effect; clear_done[1] on the same edge as tc -> done_o[1]=1.
- Priority and shadowing: ch2 up limit 10; after 4 counts, cfg write of limit 2 plus start while en=1 -> count_o ch2 = 0 (start wins); the new run reaches tc at count 2.
- Zero limit: ch3 limit 0, start -> tc_o[3] in the next cycle, channel in HOLD, count 0.
- finish_req: arm ch0 (saturate, limit 2) and ch1 (limit 4), leave others unarmed -> exactly one finish_req_o pulse, in the cycle after ch1's tc; none after ch0's tc.
- Wrap-around arithmetic: WIDTH=4, up/wrap limit 15 -> count 0..15, tc at 15, reload to 0; assertions never fire.
